// File: rtl/trigger_ctrl_pkg.sv
// Shared definitions for the trigger run controller: FSM state encoding and data widths.
package trigger_ctrl_pkg;

  localparam int unsigned TRIGGER_COUNT_WIDTH  = 32;
  localparam int unsigned SAMPLE_WIDTH         = 16;
  localparam int unsigned ADC_RESOLUTION_WIDTH = 12;

  // Codes are visible on the STATE output, so the values are fixed.
  typedef enum logic [2:0] {
    StIdle    = 3'd0,
    StApply   = 3'd1,
    StSettle  = 3'd2,
    StRunning = 3'd3,
    StDrain   = 3'd4
  } run_state_e;

endpackage

// File: rtl/trigger_edge_counter.sv
// Saturating counter of trigger rising edges, gated by an enable and cleared synchronously.
module trigger_edge_counter
  import trigger_ctrl_pkg::*;
#(
  parameter int unsigned COUNT_WIDTH = TRIGGER_COUNT_WIDTH
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   clear,
  input  logic                   enable,
  input  logic                   trigger,
  output logic [COUNT_WIDTH-1:0] count
);

  logic                   trigger_q;
  logic [COUNT_WIDTH-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (enable && trigger && !trigger_q && !(&count_q)) begin
      count_d = count_q + COUNT_WIDTH'(1);
    end
  end

  // The previous trigger level is tracked in every state so an edge straddling
  // entry into RUNNING is judged against the real prior level.
  always_ff @(posedge clk) begin
    if (rst) begin
      trigger_q <= 1'b0;
      count_q   <= '0;
    end else begin
      trigger_q <= trigger;
      count_q   <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/trigger_run_controller.sv
// Run-control FSM: shadow/active trigger configuration, settle window after each apply,
// backpressure-driven trigger inhibit and per-run trigger counting.
module trigger_run_controller
  import trigger_ctrl_pkg::*;
#(
  parameter int unsigned MAX_PRE_ACQUISITION_LENGTH  = 2,
  parameter int unsigned MAX_POST_ACQUISITION_LENGTH = 2
) (
  input  logic                                           ACLK,
  input  logic                                           ARESET,
  input  logic                                           RUN_START,
  input  logic                                           RUN_STOP,
  input  logic                                           CFG_WRITE,
  input  logic signed [SAMPLE_WIDTH-1:0]                 CFG_RISING_EDGE_THRESHOLD,
  input  logic signed [SAMPLE_WIDTH-1:0]                 CFG_FALLING_EDGE_THRESHOLD,
  input  logic [$clog2(MAX_PRE_ACQUISITION_LENGTH):0]    CFG_PRE_ACQUISITION_LENGTH,
  input  logic [$clog2(MAX_POST_ACQUISITION_LENGTH):0]   CFG_POST_ACQUISITION_LENGTH,
  input  logic signed [ADC_RESOLUTION_WIDTH-1:0]         CFG_MODE_SWITCH_UPPER_THRESOLD,
  input  logic signed [ADC_RESOLUTION_WIDTH-1:0]         CFG_MODE_SWITCH_LOWER_THRESOLD,
  input  logic                                           TRIGGER,
  input  logic                                           FIFO_ALMOST_FULL,
  output logic signed [SAMPLE_WIDTH-1:0]                 RISING_EDGE_THRESHOLD,
  output logic signed [SAMPLE_WIDTH-1:0]                 FALLING_EDGE_THRESHOLD,
  output logic [$clog2(MAX_PRE_ACQUISITION_LENGTH):0]    PRE_ACQUISITION_LENGTH,
  output logic [$clog2(MAX_POST_ACQUISITION_LENGTH):0]   POST_ACQUISITION_LENGTH,
  output logic signed [ADC_RESOLUTION_WIDTH-1:0]         MODE_SWITCH_UPPER_THRESOLD,
  output logic signed [ADC_RESOLUTION_WIDTH-1:0]         MODE_SWITCH_LOWER_THRESOLD,
  output logic                                           SET_CONFIG,
  output logic                                           STOP,
  output logic [2:0]                                     STATE,
  output logic [TRIGGER_COUNT_WIDTH-1:0]                 TRIGGER_COUNT,
  output logic                                           CFG_PENDING,
  output logic                                           CFG_ERROR
);

  localparam int unsigned PRE_WIDTH    = $clog2(MAX_PRE_ACQUISITION_LENGTH) + 1;
  localparam int unsigned POST_WIDTH   = $clog2(MAX_POST_ACQUISITION_LENGTH) + 1;
  localparam int unsigned SETTLE_WIDTH =
      $clog2(MAX_PRE_ACQUISITION_LENGTH + MAX_POST_ACQUISITION_LENGTH + 2) + 1;

  localparam logic [PRE_WIDTH-1:0]  MAX_PRE  = PRE_WIDTH'(MAX_PRE_ACQUISITION_LENGTH);
  localparam logic [POST_WIDTH-1:0] MAX_POST = POST_WIDTH'(MAX_POST_ACQUISITION_LENGTH);

  typedef struct packed {
    logic signed [SAMPLE_WIDTH-1:0]         rising;
    logic signed [SAMPLE_WIDTH-1:0]         falling;
    logic [PRE_WIDTH-1:0]                   pre;
    logic [POST_WIDTH-1:0]                  post;
    logic signed [ADC_RESOLUTION_WIDTH-1:0] upper;
    logic signed [ADC_RESOLUTION_WIDTH-1:0] lower;
  } cfg_t;

  run_state_e              state_q, state_d;
  cfg_t                    shadow_q, active_q, cfg_in;
  logic [SETTLE_WIDTH-1:0] settle_q, settle_d;
  logic                    pending_q, pending_d;
  logic                    error_q, error_d;
  logic                    stop_q, stop_d;
  logic                    set_config_q, set_config_d;
  logic                    cfg_accept;
  logic                    count_clear;
  logic                    count_enable;

  assign cfg_in = '{
    rising:  CFG_RISING_EDGE_THRESHOLD,
    falling: CFG_FALLING_EDGE_THRESHOLD,
    pre:     CFG_PRE_ACQUISITION_LENGTH,
    post:    CFG_POST_ACQUISITION_LENGTH,
    upper:   CFG_MODE_SWITCH_UPPER_THRESOLD,
    lower:   CFG_MODE_SWITCH_LOWER_THRESOLD
  };

  assign cfg_accept = CFG_WRITE && (CFG_PRE_ACQUISITION_LENGTH <= MAX_PRE) &&
                      (CFG_POST_ACQUISITION_LENGTH <= MAX_POST);

  always_comb begin
    state_d  = state_q;
    settle_d = settle_q;
    unique case (state_q)
      StIdle: begin
        if (RUN_START) state_d = StApply;
      end
      StApply: begin
        // Active lengths already hold the freshly applied values here.
        state_d  = StSettle;
        settle_d = SETTLE_WIDTH'(active_q.pre) + SETTLE_WIDTH'(active_q.post) +
                   SETTLE_WIDTH'(1);
      end
      StSettle: begin
        if (settle_q == '0) begin
          state_d = StRunning;
        end else begin
          settle_d = settle_q - SETTLE_WIDTH'(1);
        end
      end
      StRunning: begin
        if (RUN_STOP) begin
          state_d = StDrain;
        end else if (pending_q && !TRIGGER) begin
          state_d = StApply;
        end
      end
      StDrain: begin
        if (!TRIGGER) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Registered outputs are computed from the next state so they line up with STATE.
  always_comb begin
    set_config_d = (state_d == StApply);
    stop_d       = (state_d == StRunning) ? FIFO_ALMOST_FULL : 1'b1;
    pending_d    = pending_q;
    error_d      = error_q;
    if (cfg_accept) begin
      pending_d = 1'b1;
      error_d   = 1'b0;
    end else begin
      if (set_config_d) pending_d = 1'b0;
      if (CFG_WRITE)    error_d   = 1'b1;
    end
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state_q      <= StIdle;
      settle_q     <= '0;
      shadow_q     <= '0;
      active_q     <= '0;
      pending_q    <= 1'b0;
      error_q      <= 1'b0;
      stop_q       <= 1'b1;
      set_config_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      settle_q     <= settle_d;
      pending_q    <= pending_d;
      error_q      <= error_d;
      stop_q       <= stop_d;
      set_config_q <= set_config_d;
      if (set_config_d) active_q <= shadow_q;
      if (cfg_accept)   shadow_q <= cfg_in;
    end
  end

  assign count_clear  = (state_q == StIdle) && RUN_START;
  assign count_enable = (state_q == StRunning);

  trigger_edge_counter #(
    .COUNT_WIDTH(TRIGGER_COUNT_WIDTH)
  ) u_edge_counter (
    .clk    (ACLK),
    .rst    (ARESET),
    .clear  (count_clear),
    .enable (count_enable),
    .trigger(TRIGGER),
    .count  (TRIGGER_COUNT)
  );

  assign RISING_EDGE_THRESHOLD      = active_q.rising;
  assign FALLING_EDGE_THRESHOLD     = active_q.falling;
  assign PRE_ACQUISITION_LENGTH     = active_q.pre;
  assign POST_ACQUISITION_LENGTH    = active_q.post;
  assign MODE_SWITCH_UPPER_THRESOLD = active_q.upper;
  assign MODE_SWITCH_LOWER_THRESOLD = active_q.lower;
  assign SET_CONFIG                 = set_config_q;
  assign STOP                       = stop_q;
  assign STATE                      = state_q;
  assign CFG_PENDING                = pending_q;
  assign CFG_ERROR                  = error_q;

endmodule

// File: tb/tb_trigger_run_controller.sv
// Bench for trigger_run_controller: directed scenarios then random traffic, all compared
// every cycle against a transaction-level reference model.
module tb_trigger_run_controller;
  import trigger_ctrl_pkg::*;

  localparam int MAX_PRE  = 2;
  localparam int MAX_POST = 2;
  localparam int PW       = $clog2(MAX_PRE) + 1;
  localparam int QW       = $clog2(MAX_POST) + 1;

  logic ACLK = 1'b0;
  always #5 ACLK = ~ACLK;

  logic areset = 1'b1, run_start = 1'b0, run_stop = 1'b0, cfg_write = 1'b0;
  logic trigger = 1'b0, faf = 1'b0;
  logic signed [SAMPLE_WIDTH-1:0]         cfg_rise = '0, cfg_fall = '0, rise, fall;
  logic [PW-1:0]                          cfg_pre = '0, pre;
  logic [QW-1:0]                          cfg_post = '0, post;
  logic signed [ADC_RESOLUTION_WIDTH-1:0] cfg_up = '0, cfg_lo = '0, up, lo;
  logic                                   set_config, stop, pending, error;
  logic [2:0]                             state;
  logic [31:0]                            trig_count;

  trigger_run_controller #(
    .MAX_PRE_ACQUISITION_LENGTH (MAX_PRE),
    .MAX_POST_ACQUISITION_LENGTH(MAX_POST)
  ) dut (
    .ACLK                          (ACLK),
    .ARESET                        (areset),
    .RUN_START                     (run_start),
    .RUN_STOP                      (run_stop),
    .CFG_WRITE                     (cfg_write),
    .CFG_RISING_EDGE_THRESHOLD     (cfg_rise),
    .CFG_FALLING_EDGE_THRESHOLD    (cfg_fall),
    .CFG_PRE_ACQUISITION_LENGTH    (cfg_pre),
    .CFG_POST_ACQUISITION_LENGTH   (cfg_post),
    .CFG_MODE_SWITCH_UPPER_THRESOLD(cfg_up),
    .CFG_MODE_SWITCH_LOWER_THRESOLD(cfg_lo),
    .TRIGGER                       (trigger),
    .FIFO_ALMOST_FULL              (faf),
    .RISING_EDGE_THRESHOLD         (rise),
    .FALLING_EDGE_THRESHOLD        (fall),
    .PRE_ACQUISITION_LENGTH        (pre),
    .POST_ACQUISITION_LENGTH       (post),
    .MODE_SWITCH_UPPER_THRESOLD    (up),
    .MODE_SWITCH_LOWER_THRESOLD    (lo),
    .SET_CONFIG                    (set_config),
    .STOP                          (stop),
    .STATE                         (state),
    .TRIGGER_COUNT                 (trig_count),
    .CFG_PENDING                   (pending),
    .CFG_ERROR                     (error)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: phases 0..4 as named in the requirements, config kept as plain ints.
  typedef struct {
    int rise;
    int fall;
    int pre;
    int post;
    int up;
    int lo;
  } mcfg_t;

  mcfg_t  m_act, m_sh;
  int     m_state, m_settle_left;
  bit     m_stop, m_setcfg, m_pending, m_error, m_prev;
  longint m_count;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_edge();
    int  nxt;
    bit  accept;
    bit  entering;
    if (areset) begin
      m_state = 0; m_stop = 1'b1; m_setcfg = 1'b0; m_pending = 1'b0; m_error = 1'b0;
      m_count = 0; m_prev = 1'b0; m_settle_left = 0;
      m_act = '{default: 0};
      m_sh  = '{default: 0};
      return;
    end
    accept = cfg_write && (int'(cfg_pre) <= MAX_PRE) && (int'(cfg_post) <= MAX_POST);
    nxt = m_state;
    case (m_state)
      0: if (run_start) nxt = 1;
      1: begin
        nxt = 2;
        m_settle_left = m_act.pre + m_act.post + 2;
      end
      2: begin
        m_settle_left--;
        if (m_settle_left == 0) nxt = 3;
      end
      3: begin
        if (run_stop) nxt = 4;
        else if (m_pending && !trigger) nxt = 1;
      end
      4: if (!trigger) nxt = 0;
      default: nxt = 0;
    endcase
    if (m_state == 3 && trigger && !m_prev && m_count < 64'hFFFF_FFFF) m_count++;
    if (m_state == 0 && run_start) m_count = 0;
    m_prev   = trigger;
    entering = (nxt == 1);
    if (entering) m_act = m_sh;
    m_setcfg = entering;
    if (accept) begin
      m_sh = '{rise: int'(cfg_rise), fall: int'(cfg_fall), pre: int'(cfg_pre),
               post: int'(cfg_post), up: int'(cfg_up), lo: int'(cfg_lo)};
      m_pending = 1'b1;
      m_error   = 1'b0;
    end else begin
      if (entering)  m_pending = 1'b0;
      if (cfg_write) m_error   = 1'b1;
    end
    m_stop  = (nxt == 3) ? faf : 1'b1;
    m_state = nxt;
  endtask

  task automatic check_all();
    chk("state",         64'(state),      64'(m_state));
    chk("stop",          64'(stop),       64'(m_stop));
    chk("set_config",    64'(set_config), 64'(m_setcfg));
    chk("trigger_count", 64'(trig_count), 64'(m_count));
    chk("cfg_pending",   64'(pending),    64'(m_pending));
    chk("cfg_error",     64'(error),      64'(m_error));
    chk("rising_thr",    64'(rise),       64'(m_act.rise));
    chk("falling_thr",   64'(fall),       64'(m_act.fall));
    chk("pre_len",       64'(pre),        64'(m_act.pre));
    chk("post_len",      64'(post),       64'(m_act.post));
    chk("upper_thr",     64'(up),         64'(m_act.up));
    chk("lower_thr",     64'(lo),         64'(m_act.lo));
  endtask

  task automatic tick();
    model_edge();
    @(posedge ACLK);
    #1;
    check_all();
    run_start = 1'b0;
    run_stop  = 1'b0;
    cfg_write = 1'b0;
  endtask

  task automatic write_cfg(input int r, input int f, input int p, input int q, input int u,
                           input int l);
    cfg_write = 1'b1;
    cfg_rise  = SAMPLE_WIDTH'(r);
    cfg_fall  = SAMPLE_WIDTH'(f);
    cfg_pre   = PW'(p);
    cfg_post  = QW'(q);
    cfg_up    = ADC_RESOLUTION_WIDTH'(u);
    cfg_lo    = ADC_RESOLUTION_WIDTH'(l);
  endtask

  task automatic wait_running(input string tag);
    int n = 0;
    while (state != 3'd3 && n < 30) begin
      tick();
      n++;
    end
    chk(tag, 64'(state), 64'(3));
  endtask

  initial begin
    int settle_stops;
    int extra_setcfg;
    int early_apply;

    // Reset state
    areset = 1'b1;
    tick();
    tick();
    areset = 1'b0;
    chk("reset_state", 64'(state), 64'(0));
    chk("reset_stop", 64'(stop), 64'(1));

    // Configure and start a run: apply pulse, settle window, then running
    write_cfg(100, -50, 2, 2, 1000, -1000);
    tick();
    chk("write_pending", 64'(pending), 64'(1));
    run_start = 1'b1;
    tick();
    chk("apply_set_config", 64'(set_config), 64'(1));
    chk("apply_rising", 64'(rise), 64'(100));
    chk("apply_pending_clear", 64'(pending), 64'(0));
    settle_stops = 0;
    extra_setcfg = 0;
    for (int n = 0; n < 20 && state != 3'd3; n++) begin
      tick();
      if (state == 3'd2 && stop) settle_stops++;
      if (set_config) extra_setcfg++;
    end
    chk("settle_stop_cycles", 64'(settle_stops), 64'(6));
    chk("set_config_single", 64'(extra_setcfg), 64'(0));
    chk("running_state", 64'(state), 64'(3));
    chk("running_stop", 64'(stop), 64'(0));

    // Three trigger pulses, then backpressure
    for (int i = 0; i < 3; i++) begin
      trigger = 1'b1;
      tick();
      trigger = 1'b0;
      tick();
    end
    chk("three_triggers", 64'(trig_count), 64'(3));
    faf = 1'b1;
    tick();
    chk("stop_after_faf", 64'(stop), 64'(1));
    faf = 1'b0;
    tick();
    chk("stop_release", 64'(stop), 64'(0));

    // Live reconfiguration is held off while the trigger is high
    trigger = 1'b1;
    tick();
    write_cfg(200, -60, 2, 2, 500, -500);
    tick();
    early_apply = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (state != 3'd3 || set_config) early_apply++;
    end
    chk("no_apply_while_high", 64'(early_apply), 64'(0));
    trigger = 1'b0;
    tick();
    chk("apply_after_fall", 64'(state), 64'(1));
    chk("live_set_config", 64'(set_config), 64'(1));
    chk("live_pending_clear", 64'(pending), 64'(0));
    chk("live_rising", 64'(rise), 64'(200));
    wait_running("live_back_running");

    // Out-of-range write is rejected; a following valid write clears the error
    write_cfg(999, 0, 3, 1, 0, 0);
    tick();
    chk("reject_error", 64'(error), 64'(1));
    chk("reject_pending", 64'(pending), 64'(0));
    chk("reject_active_rise", 64'(rise), 64'(200));
    chk("reject_active_pre", 64'(pre), 64'(2));
    write_cfg(300, -70, 1, 0, 700, -700);
    tick();
    chk("valid_clears_error", 64'(error), 64'(0));
    chk("valid_pending", 64'(pending), 64'(1));
    tick();
    chk("short_apply", 64'(rise), 64'(300));
    wait_running("short_settle_running");

    // Stop while the trigger is still high drains first
    trigger = 1'b1;
    tick();
    run_stop = 1'b1;
    tick();
    chk("drain_entry", 64'(state), 64'(4));
    for (int i = 0; i < 3; i++) tick();
    chk("drain_hold", 64'(state), 64'(4));
    trigger = 1'b0;
    tick();
    chk("drain_exit_idle", 64'(state), 64'(0));

    // Reset in the middle of a settle window
    write_cfg(5, 5, 2, 2, 5, 5);
    run_start = 1'b1;
    tick();
    tick();
    tick();
    chk("mid_settle", 64'(state), 64'(2));
    areset = 1'b1;
    tick();
    areset = 1'b0;
    chk("rst_state", 64'(state), 64'(0));
    chk("rst_stop", 64'(stop), 64'(1));
    chk("rst_count", 64'(trig_count), 64'(0));
    chk("rst_rise", 64'(rise), 64'(0));
    chk("rst_pending", 64'(pending), 64'(0));

    // Random traffic against the model
    for (int c = 0; c < 1500; c++) begin
      areset    = ($urandom_range(0, 249) == 0);
      run_start = ($urandom_range(0, 5) == 0);
      run_stop  = ($urandom_range(0, 14) == 0);
      if ($urandom_range(0, 7) == 0) begin
        write_cfg(int'($urandom), int'($urandom), int'($urandom_range(0, 3)),
                  int'($urandom_range(0, 3)), int'($urandom), int'($urandom));
      end
      if ($urandom_range(0, 2) == 0) trigger = ~trigger;
      faf = ($urandom_range(0, 3) == 0);
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
